char_fetcher: RTL
=================

CHAR_FETCHER -- requirements
Module: char_fetcher

Interface
REQ-001 Reset is synchronous and active-high; one clock (clk_dot4x); all state changes on posedge clk_dot4x.
REQ-002 clk_dot4x  in  1  4x dot clock, sole clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 clk_phi  in  1  PHI level; 0 = PHI1 (g-access), 1 = PHI2 (c-access).
REQ-005 phi_phase_start_15  in  1  strobe on the last dot4x tick of the current PHI phase.
REQ-006 cycle_num  in  7  raster cycle 0..62 (PAL), stable for the whole cycle.
REQ-007 raster_line  in  9  current raster line.
REQ-008 badline  in  1  badline condition for the current cycle.
REQ-009 bmm, ecm  in  1 each  bitmap mode and extended-colour mode bits.
REQ-010 vm  in  4  video matrix base, address bits 13:10.
REQ-011 cb  in  3  char/bitmap base, address bits 13:11.
REQ-012 data_in  in  12  bus data: {colour nibble[11:8], data[7:0]}.
REQ-013 vic_addr  out  14  fetch address for the current phase.
REQ-014 char_read  out  12  char + colour for the pixel sequencer.
REQ-015 pixels_read  out  8  g-access pixel byte for the pixel sequencer.
REQ-016 idle  out  1  1 = idle state, 0 = display state.

Function
REQ-017 Registered counters: vc (10b), vc_base (10b), rc (3b), vmli (6b); 40x12 line buffer.
REQ-018 Two states, IDLE and DISPLAY; badline=1 in any cycle forces DISPLAY on the phase_start_15 tick of PHI1.
REQ-019 Cycle 14, PHI1 end tick: vc <= vc_base, vmli <= 0; if badline, rc <= 0.
REQ-020 Cycle 58, PHI1 end tick: if rc==7 then vc_base <= vc and, if badline=0, state <= IDLE; if state is DISPLAY, rc <= rc+1 (3-bit wrap).
REQ-021 raster_line==0 and cycle_num==1, PHI1 end tick: vc_base <= 0; this has priority over REQ-020 for vc_base.
REQ-022 c-access: PHI2 of cycles 15..54 with badline=1; vic_addr = {vm, vc}; on PHI2 end tick, line_buffer[vmli] <= data_in.
REQ-023 If badline=0 during PHI2 of cycles 15..54, the line buffer is not written; entries hold the previous line's values.
REQ-024 g-access: PHI1 of cycles 16..55; vic_addr in DISPLAY = bmm ? {cb[2], vc, rc} : {cb, line_buffer[vmli][7:0], rc}; in IDLE = 14'h3FFF.
REQ-025 ecm=1 forces vic_addr bits 10:9 to 0 for every g-access (DISPLAY and IDLE, giving 14'h39FF in IDLE).
REQ-026 Outside the c-access and g-access windows of REQ-022 and REQ-024, vic_addr = 14'h3FFF.
REQ-027 On the PHI1 end tick of cycles 16..55: pixels_read <= data_in[7:0]; char_read <= DISPLAY ? line_buffer[vmli] : 12'h000; in DISPLAY, vc <= vc+1 (10-bit wrap) and vmli <= vmli+1.
REQ-028 In IDLE, vc and vmli do not advance during the g-access window.
REQ-029 pixels_read and char_read hold their values from one g-access to the next and change only on the tick of REQ-027.
REQ-030 pixels_read and char_read are valid before the next PHI2 end tick, which is the tick on which the pixel sequencer samples them.
REQ-031 vmli saturates at 39; if it is ever reached, writes beyond index 39 are dropped.
REQ-032 When badline rises mid-line (cycles 15..54), c-accesses start in the same cycle; vmli continues from its current value.

Reset
REQ-033 rst SHALL clear: vc, vc_base, rc, vmli <= 0; state <= IDLE; pixels_read <= 8'h00; char_read <= 12'h000; vic_addr <= 14'h3FFF; idle <= 1.
REQ-034 rst asserted mid-line SHALL abort the current fetch with no buffer write on that tick; line buffer contents are not reset.

Structure
REQ-035 The shared package/include (common.vh) SHALL hold the cycle constants: C_ACCESS_FIRST=15, C_ACCESS_LAST=54, G_ACCESS_FIRST=16, G_ACCESS_LAST=55, VC_LOAD_CYCLE=14, RC_CYCLE=58, and IDLE_ADDR=14'h3FFF.
REQ-036 The line buffer SHALL be a sub-module, matrix_line_buffer (40x12, 1 write port, 1 async read port).

Verification
REQ-037 Badline on line 0x33, cycles 15..54, data_in = {4'h5, i} -> line_buffer[i] = {5,i}; g-address = {cb,i,3'b000}; char_read = 12'h5ii in order.
REQ-038 Eight lines after the badline with no new badline -> rc counts 0..7; at cycle 58 of the rc==7 line, vc_base = 40 and idle = 1.
REQ-039 IDLE with ecm=1 -> vic_addr = 14'h39FF on every g-access; char_read = 0; vc unchanged.
REQ-040 bmm=1, vc_base=80, rc=5 -> first g-address = {cb[2],10'd80,3'd5}.
REQ-041 rst pulsed in cycle 30 of a badline -> on the next tick all outputs equal the REQ-033 values; the next frame fetches normally.

Source files
------------

// File: rtl/char_fetcher_pkg.sv
// Shared widths, raster-cycle constants and payload types for the character fetcher.
package char_fetcher_pkg;

   localparam int unsigned ADDR_W   = 14;
   localparam int unsigned CYC_W    = 7;
   localparam int unsigned RASTER_W = 9;
   localparam int unsigned VC_W     = 10;
   localparam int unsigned RC_W     = 3;
   localparam int unsigned VMLI_W   = 6;
   localparam int unsigned VM_W     = 4;
   localparam int unsigned CB_W     = 3;
   localparam int unsigned PIX_W    = 8;
   localparam int unsigned LB_DEPTH = 40;

   localparam logic [CYC_W-1:0]  C_ACCESS_FIRST = 7'd15;
   localparam logic [CYC_W-1:0]  C_ACCESS_LAST  = 7'd54;
   localparam logic [CYC_W-1:0]  G_ACCESS_FIRST = 7'd16;
   localparam logic [CYC_W-1:0]  G_ACCESS_LAST  = 7'd55;
   localparam logic [CYC_W-1:0]  VC_LOAD_CYCLE  = 7'd14;
   localparam logic [CYC_W-1:0]  RC_CYCLE       = 7'd58;
   localparam logic [CYC_W-1:0]  VCBASE_CLR_CYC = 7'd1;
   localparam logic [ADDR_W-1:0] IDLE_ADDR      = 14'h3FFF;
   localparam logic [VMLI_W-1:0] VMLI_MAX       = 6'd39;
   localparam logic [RC_W-1:0]   RC_LAST        = 3'd7;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_DISPLAY = 1'b1
   } fetch_state_t;

   // One video-matrix entry as seen on the bus: colour nibble plus character code.
   typedef struct packed {
      logic [3:0] color;
      logic [7:0] data;
   } char_word_t;

endpackage

// File: rtl/char_fetcher_if.sv
// Memory bus and pixel-sequencer outputs of the character fetcher.
interface char_fetcher_if;
   import char_fetcher_pkg::*;

   logic [ADDR_W-1:0] vic_addr;
   char_word_t        data_in;
   char_word_t        char_read;
   logic [PIX_W-1:0]  pixels_read;
   logic              idle;

   modport master (output vic_addr, char_read, pixels_read, idle, input data_in);
   modport slave  (input vic_addr, char_read, pixels_read, idle, output data_in);
endinterface

// File: rtl/matrix_line_buffer.sv
// 40-entry video-matrix line buffer: one synchronous write port, one async read port.
module matrix_line_buffer
   import char_fetcher_pkg::*;
(
   input  logic              clk_dot4x,
   input  logic              we,
   input  logic [VMLI_W-1:0] waddr,
   input  char_word_t        wdata,
   input  logic [VMLI_W-1:0] raddr,
   output char_word_t        rdata_c
);

   char_word_t mem [LB_DEPTH];

   // Write port; indices past the last entry are dropped.
   always_ff @(posedge clk_dot4x) begin
      if (we && (waddr < VMLI_W'(LB_DEPTH))) begin
         mem[waddr] <= wdata;
      end
   end

   // Async read; out-of-range index reads as zero.
   always_comb begin
      rdata_c = '0;
      if (raddr < VMLI_W'(LB_DEPTH)) begin
         rdata_c = mem[raddr];
      end
   end

endmodule

// File: rtl/char_fetcher.sv
// Character/bitmap fetch sequencer: c-accesses fill the line buffer, g-accesses fetch pixel data.
module char_fetcher
   import char_fetcher_pkg::*;
(
   input  logic                clk_dot4x,
   input  logic                rst,
   input  logic                clk_phi,
   input  logic                phi_phase_start_15,
   input  logic [CYC_W-1:0]    cycle_num,
   input  logic [RASTER_W-1:0] raster_line,
   input  logic                badline,
   input  logic                bmm,
   input  logic                ecm,
   input  logic [VM_W-1:0]     vm,
   input  logic [CB_W-1:0]     cb,
   char_fetcher_if.master      bus
);

   fetch_state_t      state, state_nxt;
   logic [VC_W-1:0]   vc, vc_base;
   logic [RC_W-1:0]   rc;
   logic [VMLI_W-1:0] vmli;
   logic [ADDR_W-1:0] addr_c;
   char_word_t        lb_rdata_c;
   logic              phi1_end_c, in_c_win_c, in_g_win_c, c_access_c, g_access_c, lb_we_c;

   assign phi1_end_c = phi_phase_start_15 && !clk_phi;
   assign in_c_win_c = (cycle_num >= C_ACCESS_FIRST) && (cycle_num <= C_ACCESS_LAST);
   assign in_g_win_c = (cycle_num >= G_ACCESS_FIRST) && (cycle_num <= G_ACCESS_LAST);
   assign c_access_c = clk_phi && in_c_win_c && badline;
   assign g_access_c = !clk_phi && in_g_win_c;
   // A reset on the end tick aborts the pending c-access write.
   assign lb_we_c    = c_access_c && phi_phase_start_15 && !rst;

   matrix_line_buffer u_line_buffer (
      .clk_dot4x (clk_dot4x),
      .we        (lb_we_c),
      .waddr     (vmli),
      .wdata     (bus.data_in),
      .raddr     (vmli),
      .rdata_c   (lb_rdata_c)
   );

   // State register.
   always_ff @(posedge clk_dot4x) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: badline forces display; row 7 without badline drops to idle at RC_CYCLE.
   always_comb begin
      state_nxt = state;
      if (phi1_end_c) begin
         if (badline) begin
            state_nxt = ST_DISPLAY;
         end else if ((cycle_num == RC_CYCLE) && (rc == RC_LAST)) begin
            state_nxt = ST_IDLE;
         end
      end
   end

   // Fetch address for the current phase; ECM clears bits 10:9 of every g-access.
   always_comb begin
      addr_c = IDLE_ADDR;
      if (c_access_c) begin
         addr_c = {vm, vc};
      end else if (g_access_c) begin
         if (state == ST_DISPLAY) begin
            addr_c = bmm ? {cb[2], vc, rc} : {cb, lb_rdata_c.data, rc};
         end
         if (ecm) begin
            addr_c[10:9] = 2'b00;
         end
      end
   end

   // Counters and registered outputs.
   always_ff @(posedge clk_dot4x) begin
      if (rst) begin
         vc              <= '0;
         vc_base         <= '0;
         rc              <= '0;
         vmli            <= '0;
         bus.vic_addr    <= IDLE_ADDR;
         bus.char_read   <= '0;
         bus.pixels_read <= '0;
         bus.idle        <= 1'b1;
      end else begin
         bus.vic_addr <= addr_c;
         bus.idle     <= (state_nxt == ST_IDLE);
         if (phi1_end_c) begin
            if (cycle_num == VC_LOAD_CYCLE) begin
               vc   <= vc_base;
               vmli <= '0;
               if (badline) begin
                  rc <= '0;
               end
            end
            if (cycle_num == RC_CYCLE) begin
               if (rc == RC_LAST) begin
                  vc_base <= vc;
               end
               if (state == ST_DISPLAY) begin
                  rc <= rc + RC_W'(1);
               end
            end
            if ((raster_line == RASTER_W'(0)) && (cycle_num == VCBASE_CLR_CYC)) begin
               vc_base <= '0;
            end
            if (in_g_win_c) begin
               bus.pixels_read <= bus.data_in.data;
               bus.char_read   <= (state == ST_DISPLAY) ? lb_rdata_c : '0;
               if (state == ST_DISPLAY) begin
                  vc <= vc + VC_W'(1);
                  if (vmli != VMLI_MAX) begin
                     vmli <= vmli + VMLI_W'(1);
                  end
               end
            end
         end
      end
   end

endmodule
